// File: rtl/rf_cmd_sequencer.sv
// Command program buffer for the register-file ALU stage.
// Loads bytes over valid/ready, then replays them back-to-back for N passes.
module rf_cmd_sequencer #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          run,
    input  logic [7:0]    rep_count,
    input  logic          clear,
    output logic [7:0]    cmd_out,
    output logic          cmd_valid,
    output logic          busy,
    output logic [AW:0]   prog_len,
    output logic          overflow
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    passes_q, passes_d;
    logic [7:0]    cmd_out_q, cmd_out_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          overflow_q, overflow_d;
    logic          buf_we;
    logic [7:0]    buf_q [DEPTH];
    logic          last;

    assign in_ready  = (state_q == LOAD) && (len_q != FULL) && !run && !clear;
    assign busy      = (state_q == RUN);
    assign cmd_out   = cmd_out_q;
    assign cmd_valid = cmd_valid_q;
    assign prog_len  = len_q;
    assign overflow  = overflow_q;

    // pc wraps at the program length, not at the buffer size
    assign last = ({1'b0, pc_q} + (AW+1)'(1)) == len_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pc_d        = pc_q;
        passes_d    = passes_q;
        cmd_out_d   = cmd_out_q;
        cmd_valid_d = 1'b0;
        overflow_d  = overflow_q;
        buf_we      = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (clear) begin
                    len_d      = '0;
                    overflow_d = 1'b0;
                end else begin
                    if (in_valid && len_q == FULL) begin
                        overflow_d = 1'b1;
                    end
                    if (run && len_q != '0) begin
                        pc_d     = '0;
                        passes_d = rep_count;
                        state_d  = RUN;
                    end else if (in_valid && in_ready) begin
                        buf_we = 1'b1;
                        len_d  = len_q + (AW+1)'(1);
                    end
                end
            end
            RUN: begin
                // abort drops the command that would have issued this edge
                if (clear) begin
                    state_d = LOAD;
                end else begin
                    cmd_out_d   = buf_q[pc_q];
                    cmd_valid_d = 1'b1;
                    if (last) begin
                        pc_d = '0;
                        if (passes_q == 8'd0) begin
                            state_d = LOAD;
                        end else begin
                            passes_d = passes_q - 8'd1;
                        end
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            len_q       <= '0;
            pc_q        <= '0;
            passes_q    <= '0;
            cmd_out_q   <= '0;
            cmd_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pc_q        <= pc_d;
            passes_q    <= passes_d;
            cmd_out_q   <= cmd_out_d;
            cmd_valid_q <= cmd_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[len_q[AW-1:0]] <= in_data;
        end
    end

endmodule
